// File: rtl/cache_line_mem_if_if.sv
// Request/response bundle between the cache controller (master) and the line sequencer (slave).
// A request is accepted on a rising edge where req_valid && req_ready; rsp_valid is a one-cycle pulse with no backpressure.
interface cache_line_mem_if_if #(
    parameter int LINE_WORDS = 4,
    parameter int ADDR_W     = 32
);
    logic                     req_valid;
    logic                     req_ready;
    logic                     req_we;
    logic [ADDR_W-1:0]        req_addr;
    logic [LINE_WORDS*32-1:0] wr_line;
    logic                     rsp_valid;
    logic [LINE_WORDS*32-1:0] rd_line;

    modport master (
        output req_valid, req_we, req_addr, wr_line,
        input  req_ready, rsp_valid, rd_line
    );

    modport slave (
        input  req_valid, req_we, req_addr, wr_line,
        output req_ready, rsp_valid, rd_line
    );
endinterface

// File: rtl/cache_line_mem_if.sv
// Line sequencer: turns a line fill into 4*LINE_WORDS byte reads and a writeback into
// LINE_WORDS word writes on a byte-organised RAM. RAM pins are Moore outputs of state/counters.
module cache_line_mem_if #(
    parameter int LINE_WORDS = 4,
    parameter int ADDR_W     = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    cache_line_mem_if_if.slave bus,
    output logic [ADDR_W-1:0]  mem_addr,
    inout  tri   [31:0]        mem_data,
    output logic               mem_ce_n,
    output logic               mem_we_n,
    output logic               mem_oe_n,
    output logic               mem_bw,
    output logic [1:0]         debug_state
);
    localparam int OFF_W  = $clog2(LINE_WORDS * 4);
    localparam int WCNT_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam logic [WCNT_W-1:0] LAST_W = WCNT_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                   state;
    state_t                   state_nxt;
    logic [ADDR_W-1:0]        base;
    logic [LINE_WORDS*32-1:0] wr_buf;
    logic [LINE_WORDS*32-1:0] rd_buf;
    logic [WCNT_W-1:0]        w;
    logic [1:0]               b;
    logic                     drive;
    logic [31:0]              wr_word;

    assign wr_word     = wr_buf[32'(w) * 32 +: 32];
    assign mem_data    = drive ? wr_word : 32'hzzzz_zzzz;
    assign bus.rd_line = rd_buf;
    assign debug_state = state;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state  <= IDLE;
            base   <= '0;
            wr_buf <= '0;
            rd_buf <= '0;
            w      <= '0;
            b      <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        base   <= {bus.req_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
                        wr_buf <= bus.wr_line;
                        w      <= '0;
                        b      <= '0;
                    end
                end
                RD: begin
                    // {w,b} is the byte index within the line, little-endian
                    rd_buf[32'({w, b}) * 8 +: 8] <= mem_data[7:0];
                    b <= b + 2'd1;
                    if (b == 2'd3) begin
                        w <= w + WCNT_W'(1);
                    end
                end
                WR: begin
                    w <= w + WCNT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        state_nxt     = state;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        mem_addr      = '0;
        mem_ce_n      = 1'b1;
        mem_we_n      = 1'b1;
        mem_oe_n      = 1'b1;
        mem_bw        = 1'b0;
        drive         = 1'b0;
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    state_nxt = bus.req_we ? WR : RD;
                end
            end
            RD: begin
                mem_ce_n = 1'b0;
                mem_oe_n = 1'b0;
                mem_addr = base + ADDR_W'({w, b});
                if (w == LAST_W && b == 2'd3) begin
                    state_nxt = DONE;
                end
            end
            WR: begin
                mem_ce_n = 1'b0;
                mem_we_n = 1'b0;
                mem_bw   = 1'b1;
                drive    = 1'b1;
                mem_addr = base + ADDR_W'({w, 2'b00});
                if (w == LAST_W) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                bus.rsp_valid = 1'b1;
                state_nxt     = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_cache_line_mem_if.sv
// Bench for cache_line_mem_if: a byte RAM model on the pins and a shadow memory that
// predicts every beat, the response timing and the assembled fill line.
module tb_cache_line_mem_if;
  localparam int LINE_WORDS = 4;
  localparam int ADDR_W     = 32;
  localparam int LINE_W     = LINE_WORDS * 32;
  localparam int EW         = 4 + ADDR_W + 32;
  localparam int RAM_BYTES  = 1024;
  // strobe nibble is {ce_n, we_n, oe_n, bw}
  localparam logic [3:0] STB_RD  = 4'b0100;
  localparam logic [3:0] STB_WR  = 4'b0011;
  localparam logic [3:0] STB_OFF = 4'b1110;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  cache_line_mem_if_if #(.LINE_WORDS(LINE_WORDS), .ADDR_W(ADDR_W)) bus ();

  logic [ADDR_W-1:0] mem_addr;
  wire  [31:0]       mem_data;
  logic              mem_ce_n;
  logic              mem_we_n;
  logic              mem_oe_n;
  logic              mem_bw;
  logic [1:0]        debug_state;

  cache_line_mem_if #(.LINE_WORDS(LINE_WORDS), .ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .mem_ce_n    (mem_ce_n),
    .mem_we_n    (mem_we_n),
    .mem_oe_n    (mem_oe_n),
    .mem_bw      (mem_bw),
    .debug_state (debug_state)
  );

  // ---------------- RAM model (aliased to 1 KiB) ----------------
  logic [7:0] ram    [RAM_BYTES];
  logic [7:0] shadow [RAM_BYTES];

  assign mem_data = (!mem_ce_n && !mem_oe_n) ? {24'h0, ram[mem_addr[9:0]]} : 32'hzzzz_zzzz;

  always @(posedge clk) begin
    if (!mem_ce_n && !mem_we_n && mem_bw) begin
      for (int k = 0; k < 4; k++) begin
        ram[10'(mem_addr + 32'(k))] <= mem_data[8*k +: 8];
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      assert (!(!mem_we_n && !mem_oe_n))
        else $error("FAIL bus_contention: we_n=%b oe_n=%b both low", mem_we_n, mem_oe_n);
      if (!mem_oe_n) begin
        assert (mem_data == {24'h0, ram[mem_addr[9:0]]})
          else $error("FAIL read_bus_driven: data=%h required %h", mem_data, {24'h0, ram[mem_addr[9:0]]});
      end
    end
  end

  // ---------------- scoreboard ----------------
  int vectors = 0;
  int miscompares = 0;
  logic [EW-1:0]     exp_q[$];
  logic [LINE_W-1:0] rd_line_model = '0;

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] l;
    for (int i = 0; i < LINE_WORDS; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  // ---------------- driver + per-request checks ----------------
  task automatic run_req(input bit we, input logic [ADDR_W-1:0] addr,
                         input logic [LINE_W-1:0] line, input bit hold_valid);
    int n;
    int beats;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] a;
    logic [EW-1:0] exp_v;
    logic [EW-1:0] obs_v;
    logic [LINE_W-1:0] exp_fill;
    string nm;
    nm = we ? "wr" : "rd";
    n = 0;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (bus.req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_ready_timeout: req_ready=%b required 1", nm, bus.req_ready);
    end
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.wr_line   = line;

    base = addr & ~ADDR_W'(LINE_WORDS * 4 - 1);
    exp_q.delete();
    exp_fill = '0;
    if (we) begin
      beats = LINE_WORDS;
      for (int i = 0; i < LINE_WORDS; i++) begin
        a = base + 32'(4 * i);
        exp_q.push_back({STB_WR, a, line[i*32 +: 32]});
        for (int k = 0; k < 4; k++) shadow[10'(a + 32'(k))] = line[i*32 + 8*k +: 8];
      end
    end else begin
      beats = 4 * LINE_WORDS;
      for (int i = 0; i < 4 * LINE_WORDS; i++) begin
        a = base + 32'(i);
        exp_q.push_back({STB_RD, a, {24'h0, shadow[a[9:0]]}});
        exp_fill[i*8 +: 8] = shadow[a[9:0]];
      end
    end

    @(posedge clk);
    #1;
    if (!hold_valid) begin
      bus.req_valid = 1'b0;
      bus.req_we    = 1'($urandom_range(0, 1));
      bus.req_addr  = $urandom;
      bus.wr_line   = rand_line();
    end

    for (int i = 0; i < beats; i++) begin
      @(negedge clk);
      exp_v = exp_q.pop_front();
      obs_v = {mem_ce_n, mem_we_n, mem_oe_n, mem_bw, mem_addr, mem_data};
      vectors++;
      if (obs_v !== exp_v || bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL %s_beat%0d: got stb=%b addr=%h data=%h rsp=%b rdy=%b, required stb=%b addr=%h data=%h rsp=0 rdy=0",
                 nm, i, obs_v[EW-1 -: 4], obs_v[63:32], obs_v[31:0], bus.rsp_valid, bus.req_ready,
                 exp_v[EW-1 -: 4], exp_v[63:32], exp_v[31:0]);
      end
    end
    if (!we) rd_line_model = exp_fill;

    @(negedge clk);
    vectors++;
    if (bus.rsp_valid !== 1'b1 || bus.req_ready !== 1'b0 ||
        {mem_ce_n, mem_we_n, mem_oe_n, mem_bw} !== STB_OFF || bus.rd_line !== rd_line_model) begin
      miscompares++;
      $display("FAIL %s_done: rsp=%b rdy=%b stb=%b rd_line=%h, required rsp=1 rdy=0 stb=%b rd_line=%h",
               nm, bus.rsp_valid, bus.req_ready, {mem_ce_n, mem_we_n, mem_oe_n, mem_bw},
               bus.rd_line, STB_OFF, rd_line_model);
    end

    @(negedge clk);
    vectors++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1 || mem_addr !== '0 ||
        {mem_ce_n, mem_we_n, mem_oe_n, mem_bw} !== STB_OFF || bus.rd_line !== rd_line_model) begin
      miscompares++;
      $display("FAIL %s_idle: rsp=%b rdy=%b stb=%b addr=%h rd_line=%h, required rsp=0 rdy=1 stb=%b addr=0 rd_line=%h",
               nm, bus.rsp_valid, bus.req_ready, {mem_ce_n, mem_we_n, mem_oe_n, mem_bw}, mem_addr,
               bus.rd_line, STB_OFF, rd_line_model);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1 || mem_addr !== '0 ||
        {mem_ce_n, mem_we_n, mem_oe_n, mem_bw} !== STB_OFF || bus.rd_line !== '0) begin
      miscompares++;
      $display("FAIL reset_values: rsp=%b rdy=%b stb=%b addr=%h rd_line=%h, required 0 1 %b 0 0",
               bus.rsp_valid, bus.req_ready, {mem_ce_n, mem_we_n, mem_oe_n, mem_bw}, mem_addr,
               bus.rd_line, STB_OFF);
    end
    reset_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.req_ready !== 1'b1 || {mem_ce_n, mem_we_n, mem_oe_n, mem_bw} !== STB_OFF) begin
      miscompares++;
      $display("FAIL reset_release: rdy=%b stb=%b, required 1 %b",
               bus.req_ready, {mem_ce_n, mem_we_n, mem_oe_n, mem_bw}, STB_OFF);
    end
  endtask

  task automatic test_writeback();
    run_req(1'b1, 32'h1001_0000, {32'hDDEEFF00, 32'h99AABBCC, 32'h55667788, 32'h11223344}, 1'b0);
  endtask

  task automatic test_fill();
    run_req(1'b0, 32'h1001_0000, rand_line(), 1'b0);
    vectors++;
    if (bus.rd_line[31:0] !== 32'h11223344 || bus.rd_line[127:96] !== 32'hDDEEFF00) begin
      miscompares++;
      $display("FAIL fill_words: word0=%h word3=%h, required 11223344 ddeeff00",
               bus.rd_line[31:0], bus.rd_line[127:96]);
    end
  endtask

  task automatic test_unaligned();
    logic [31:0] w0;
    w0 = 32'hDEADBEEF;
    for (int k = 0; k < 4; k++) begin
      ram[10'h010 + 10'(k)]    = w0[8*k +: 8];
      shadow[10'h010 + 10'(k)] = w0[8*k +: 8];
    end
    run_req(1'b0, 32'h1001_001B, rand_line(), 1'b0);
    vectors++;
    if (bus.rd_line[31:0] !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL unaligned_word0: got %h required deadbeef", bus.rd_line[31:0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [ADDR_W-1:0] a;
    a = $urandom;
    run_req(1'b0, a, rand_line(), 1'b1);
    run_req(1'b0, a, rand_line(), 1'b0);
  endtask

  task automatic test_random();
    for (int t = 0; t < 12; t++) begin
      run_req(1'($urandom_range(0, 1)), $urandom, rand_line(), 1'b0);
    end
    run_req(1'b1, 32'hFFFF_FFF7, rand_line(), 1'b0);
    run_req(1'b0, 32'hFFFF_FFF7, rand_line(), 1'b0);
  endtask

  task automatic test_reset_mid_wr();
    logic [LINE_W-1:0] line;
    logic [ADDR_W-1:0] base;
    line = rand_line();
    base = 32'h0000_0200;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = base;
    bus.wr_line   = line;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    // words 0 and 1 reach the RAM before the reset edge takes effect
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 4; k++) shadow[10'(base + 32'(4 * i + k))] = line[i*32 + 8*k +: 8];
    reset_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      @(negedge clk);
      vectors++;
      if (bus.rsp_valid !== 1'b0 || {mem_ce_n, mem_we_n, mem_oe_n, mem_bw} !== STB_OFF) begin
        miscompares++;
        $display("FAIL reset_mid_wr_c%0d: rsp=%b stb=%b, required 0 %b",
                 c, bus.rsp_valid, {mem_ce_n, mem_we_n, mem_oe_n, mem_bw}, STB_OFF);
      end
    end
    reset_n = 1'b1;
    rd_line_model = '0;
    @(negedge clk);
    vectors++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1 || mem_addr !== '0 ||
        {mem_ce_n, mem_we_n, mem_oe_n, mem_bw} !== STB_OFF || bus.rd_line !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_wr_after: rsp=%b rdy=%b stb=%b addr=%h rd_line=%h, required 0 1 %b 0 0",
               bus.rsp_valid, bus.req_ready, {mem_ce_n, mem_we_n, mem_oe_n, mem_bw}, mem_addr,
               bus.rd_line, STB_OFF);
    end
    run_req(1'b0, base, rand_line(), 1'b0);
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.wr_line   = '0;
    for (int i = 0; i < RAM_BYTES; i++) begin
      ram[i]    = 8'($urandom);
      shadow[i] = ram[i];
    end
    test_reset();
    test_writeback();
    test_fill();
    test_unaligned();
    test_back_to_back();
    test_random();
    test_reset_mid_wr();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/cache_line_mem_if.md
Name: cache_line_mem_if

Overview:
- Memory-side sequencer between the cache controller and the byte-organised RAM. It converts one line-fill or line-writeback request into a series of strobed RAM accesses.
- Reads assemble each 32-bit word from four byte reads, because the RAM returns one byte per access on data[7:0].
- Writes use one word-wide access (bw=1) per word.
- The RAM-side pins connect directly to the RAM's addr/data/ce_n/we_n/oe_n/bw.

Parameters:
- LINE_WORDS, 4, 32-bit words per cache line; power of 2, range 1..16.
- ADDR_W, 32, address width on both sides.

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset, synchronous, active-low
- req_valid  in  1  cache request valid
- req_ready  out  1  block can accept a request (high only in IDLE)
- req_we  in  1  1 = line writeback, 0 = line fill
- req_addr  in  ADDR_W  line address; low log2(LINE_WORDS*4) bits ignored and forced to 0
- wr_line  in  LINE_WORDS*32  writeback data; word w = bits [w*32+:32]
- rsp_valid  out  1  one-cycle pulse when the request completes
- rd_line  out  LINE_WORDS*32  fill data; byte b of word w = bits [w*32+b*8+:8]; little-endian
- mem_addr  out  ADDR_W  RAM byte address
- mem_data  inout  32  RAM data bus
- mem_ce_n  out  1  RAM chip enable, active-low
- mem_we_n  out  1  RAM write enable, active-low
- mem_oe_n  out  1  RAM output enable, active-low
- mem_bw  out  1  RAM word-write select (1 = 4 bytes)

Behaviour:
- Reset:
  - Synchronous, active-low reset_n.
  - State goes to IDLE; all counters clear; rd_line clears to 0; base address register clears to 0.
  - rsp_valid=0, req_ready=1, mem_ce_n=mem_we_n=mem_oe_n=1, mem_bw=0, mem_addr=0, mem_data released (high-Z).
- Reset mid-operation: the access is aborted on that edge; no rsp_valid is issued; partially captured data is discarded.
- All RAM-side outputs are Moore: decoded from registered state and counters only, with no combinational path from req_* to mem_*.
- FSM states: IDLE, RD, WR, DONE.
- IDLE:
  - req_ready=1.
  - On an edge with req_valid=1, latch base = req_addr with the offset bits zeroed, latch wr_line and req_we, and clear word counter w and byte counter b.
  - Next state is WR if req_we=1, else RD.
- RD:
  - Drives mem_ce_n=0, mem_oe_n=0, mem_we_n=1, mem_bw=0, mem_addr = base + 4*w + b.
  - mem_data is not driven.
  - At each edge, capture mem_data[7:0] into rd_line byte (w,b), then increment b.
  - When b=3, wrap b to 0 and increment w.
  - After byte (LINE_WORDS-1, 3) is captured, go to DONE.
  - Duration: exactly 4*LINE_WORDS cycles.
- WR:
  - Drives mem_ce_n=0, mem_we_n=0, mem_oe_n=1, mem_bw=1, mem_addr = base + 4*w.
  - mem_data = latched wr_line word w; this is the only state in which mem_data is driven.
  - Increment w each edge.
  - After word LINE_WORDS-1, go to DONE.
  - Duration: LINE_WORDS cycles.
- DONE:
  - All strobes high; bus released.
  - rsp_valid=1 for exactly one cycle.
  - rd_line is held stable from DONE until the next RD begins; it is not updated by WR.
  - Next state is IDLE.
- Latency from the accept edge to the rsp_valid cycle:
  - Fill: 4*LINE_WORDS + 1 cycles.
  - Writeback: LINE_WORDS + 1 cycles.
- Back-to-back requests: req_valid held high during DONE is not accepted until IDLE, so there is a minimum of one IDLE cycle between requests.
- The block never drives mem_data while mem_oe_n=0; the bus is high-Z in IDLE, RD and DONE.
- req_addr and wr_line may change after the accept edge without effect.
- Address arithmetic is modulo 2^ADDR_W; a line at the top of the address space wraps silently.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles mid-WR. Next cycle: mem_ce_n=mem_we_n=mem_oe_n=1, mem_data high-Z, req_ready=1, rsp_valid=0, rd_line=0.
- Writeback: req_we=1, req_addr=0x10010000, wr_line words {0x11223344, 0x55667788, 0x99AABBCC, 0xDDEEFF00}.
  - mem_addr steps 0x10010000/04/08/0C over 4 cycles with bw=1, we_n=0, and matching data.
  - rsp_valid pulses on cycle 5 after accept.
- Fill after the writeback above: req_we=0, same address.
  - 16 RD cycles with mem_addr 0x10010000..0x1001000F, oe_n=0.
  - rsp_valid on cycle 17; rd_line word0=0x11223344, word3=0xDDEEFF00.
- Unaligned address: req_addr=0x1001001B.
  - First mem_addr=0x10010010.
  - Read of RAM bytes 0x10010010..13 = {0xEF,0xBE,0xAD,0xDE} gives word0=0xDEADBEEF.
- Back-to-back: req_valid held high across two fills. The second accept occurs only in the IDLE cycle after DONE; no strobe overlap; each request gets exactly one rsp_valid.
- Bus contention check, asserted every cycle: mem_data is never driven while mem_oe_n=0, and mem_we_n and mem_oe_n are never both 0.
